// File: rtl/race_flow_ctrl.sv
// rtl/race_flow_ctrl.sv - game-flow FSM: race clock, countdown, leader and winner tracking
module race_flow_ctrl #(
    parameter int          CLK_FREQ      = 100_000_000,
    parameter int          COUNTDOWN_SEC = 3,
    parameter logic [15:0] TIME_MAX      = 16'd59999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        confirm_btn,
    input  logic        pause_btn,
    input  logic [1:0]  p1_flag,
    input  logic [1:0]  p2_flag,
    input  logic        p1_finish,
    input  logic        p2_finish,
    output logic [2:0]  state,
    output logic [2:0]  countdown_val,
    output logic [15:0] race_time_cs,
    output logic [1:0]  leader,
    output logic [1:0]  winner,
    output logic        sec_pulse
);

    localparam int              CS_LIMIT = CLK_FREQ / 100 - 1;
    localparam int              PS_W     = (CS_LIMIT > 1) ? $clog2(CS_LIMIT + 1) : 1;
    localparam logic [PS_W-1:0] PS_MAX   = PS_W'(CS_LIMIT);
    localparam logic [2:0]      CD_LOAD  = 3'(COUNTDOWN_SEC);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTING   = 3'd1,
        S_COUNTDOWN = 3'd3,
        S_RACING    = 3'd4,
        S_PAUSE     = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t          cur, nxt;
    logic            start_q, confirm_q, pause_q;
    logic            start_e, confirm_e, pause_e;
    logic [PS_W-1:0] ps, ps_d;
    logic [6:0]      sec_cnt, sec_d;
    logic [2:0]      cval_d;
    logic [15:0]     time_d;
    logic [1:0]      leader_d, winner_d;
    logic            pulse_d;
    logic            cs_tick, sec_boundary, any_fin, timed;

    assign start_e      = start_btn & ~start_q;
    assign confirm_e    = confirm_btn & ~confirm_q;
    assign pause_e      = pause_btn & ~pause_q;
    assign any_fin      = p1_finish | p2_finish;
    assign timed        = (cur == S_COUNTDOWN) || (cur == S_RACING);
    assign cs_tick      = timed && (ps == PS_MAX);
    assign sec_boundary = (cur == S_COUNTDOWN) && cs_tick && (sec_cnt == 7'd99);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Unknown codes fall through to the default and recover to IDLE.
    always_comb begin
        nxt = S_IDLE;
        case (cur)
            S_IDLE:      nxt = start_e ? S_SETTING : S_IDLE;
            S_SETTING:   nxt = confirm_e ? S_COUNTDOWN : (start_e ? S_IDLE : S_SETTING);
            S_COUNTDOWN: nxt = start_e ? S_IDLE :
                               ((sec_boundary && countdown_val == 3'd1) ? S_RACING : S_COUNTDOWN);
            S_RACING:    nxt = any_fin ? S_FINISH : (pause_e ? S_PAUSE : S_RACING);
            S_PAUSE:     nxt = start_e ? S_IDLE : (pause_e ? S_RACING : S_PAUSE);
            S_FINISH:    nxt = start_e ? S_IDLE : S_FINISH;
            default:     nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ps_d     = ps;
        sec_d    = sec_cnt;
        cval_d   = countdown_val;
        time_d   = race_time_cs;
        winner_d = winner;
        leader_d = 2'd0;
        pulse_d  = 1'b0;

        // Prescaler runs while timed, holds its phase through PAUSE, clears otherwise.
        if (timed) begin
            ps_d = cs_tick ? '0 : ps + 1'b1;
        end else if (cur != S_PAUSE) begin
            ps_d = '0;
        end

        if (cur == S_COUNTDOWN) begin
            if (cs_tick) begin
                sec_d = (sec_cnt == 7'd99) ? 7'd0 : sec_cnt + 7'd1;
            end
        end else begin
            sec_d = 7'd0;
        end

        if (cur == S_SETTING && nxt == S_COUNTDOWN) begin
            cval_d = CD_LOAD;
        end

        if (sec_boundary && nxt != S_IDLE) begin
            pulse_d = 1'b1;
            cval_d  = countdown_val - 3'd1;
            if (nxt == S_RACING) begin
                time_d   = 16'd0;
                winner_d = 2'd0;
            end
        end

        if (cur == S_RACING) begin
            if (cs_tick && race_time_cs < TIME_MAX) begin
                time_d = race_time_cs + 16'd1;
            end
            if (any_fin) begin
                winner_d = {p2_finish, p1_finish};
            end
        end

        // Finish level outranks any flag, so it sits above the flag bits.
        if ((cur == S_RACING || cur == S_PAUSE || cur == S_FINISH) && nxt != S_IDLE) begin
            if ({p1_finish, p1_flag} > {p2_finish, p2_flag}) begin
                leader_d = 2'd1;
            end else if ({p2_finish, p2_flag} > {p1_finish, p1_flag}) begin
                leader_d = 2'd2;
            end
        end

        if (nxt == S_IDLE) begin
            ps_d     = '0;
            time_d   = 16'd0;
            winner_d = 2'd0;
            cval_d   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q       <= 1'b0;
            confirm_q     <= 1'b0;
            pause_q       <= 1'b0;
            ps            <= '0;
            sec_cnt       <= 7'd0;
            countdown_val <= 3'd0;
            race_time_cs  <= 16'd0;
            leader        <= 2'd0;
            winner        <= 2'd0;
            sec_pulse     <= 1'b0;
        end else begin
            start_q       <= start_btn;
            confirm_q     <= confirm_btn;
            pause_q       <= pause_btn;
            ps            <= ps_d;
            sec_cnt       <= sec_d;
            countdown_val <= cval_d;
            race_time_cs  <= time_d;
            leader        <= leader_d;
            winner        <= winner_d;
            sec_pulse     <= pulse_d;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_race_flow_ctrl.sv
// tb/tb_race_flow_ctrl.sv - randomized and directed check of race_flow_ctrl against a reference model
module tb_race_flow_ctrl;

    localparam int CPS    = 1000;
    localparam int CPCS   = 10;
    localparam int CD_SEC = 3;
    localparam int TMAX   = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_btn = 1'b0, confirm_btn = 1'b0, pause_btn = 1'b0;
    logic [1:0]  p1_flag = 2'd0, p2_flag = 2'd0;
    logic        p1_finish = 1'b0, p2_finish = 1'b0;
    logic [2:0]  state, countdown_val;
    logic [15:0] race_time_cs;
    logic [1:0]  leader, winner;
    logic        sec_pulse;

    always #5 clk = ~clk;

    race_flow_ctrl #(
        .CLK_FREQ      (1000),
        .COUNTDOWN_SEC (CD_SEC),
        .TIME_MAX      (16'(TMAX))
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .confirm_btn   (confirm_btn),
        .pause_btn     (pause_btn),
        .p1_flag       (p1_flag),
        .p2_flag       (p2_flag),
        .p1_finish     (p1_finish),
        .p2_finish     (p2_finish),
        .state         (state),
        .countdown_val (countdown_val),
        .race_time_cs  (race_time_cs),
        .leader        (leader),
        .winner        (winner),
        .sec_pulse     (sec_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: countdown and race clock derived from elapsed cycle counts.
    int m_state, m_cval, m_time, m_leader, m_winner, m_pulse, m_cd, m_rt;
    bit m_ps, m_pc, m_pp;

    task automatic model_reset();
        m_state = 0; m_cval = 0; m_time = 0; m_leader = 0; m_winner = 0;
        m_pulse = 0; m_cd = 0; m_rt = 0; m_ps = 0; m_pc = 0; m_pp = 0;
    endtask

    task automatic model_step();
        int  nst, v1, v2;
        bit  se, ce, pe;
        se = start_btn && !m_ps;
        ce = confirm_btn && !m_pc;
        pe = pause_btn && !m_pp;
        m_pulse = 0;
        nst = m_state;
        case (m_state)
            0: if (se) nst = 1;
            1: begin
                if (ce) begin nst = 3; m_cval = CD_SEC; m_cd = 0; end
                else if (se) nst = 0;
            end
            3: begin
                if (se) nst = 0;
                else begin
                    m_cd++;
                    if (m_cd % CPS == 0) begin
                        m_pulse = 1;
                        if (m_cd == CD_SEC * CPS) begin
                            nst = 4; m_cval = 0; m_rt = 0; m_time = 0; m_winner = 0;
                        end else begin
                            m_cval = CD_SEC - m_cd / CPS;
                        end
                    end
                end
            end
            4: begin
                m_rt++;
                m_time = (m_rt / CPCS > TMAX) ? TMAX : m_rt / CPCS;
                if (p1_finish || p2_finish) begin
                    nst = 6;
                    m_winner = (p1_finish ? 1 : 0) + (p2_finish ? 2 : 0);
                end else if (pe) nst = 5;
            end
            5: begin
                if (se) nst = 0;
                else if (pe) nst = 4;
            end
            6: if (se) nst = 0;
            default: nst = 0;
        endcase
        if ((m_state == 4 || m_state == 5 || m_state == 6) && nst != 0) begin
            v1 = (p1_finish ? 4 : 0) + int'(p1_flag);
            v2 = (p2_finish ? 4 : 0) + int'(p2_flag);
            m_leader = (v1 > v2) ? 1 : ((v2 > v1) ? 2 : 0);
        end else begin
            m_leader = 0;
        end
        if (nst == 0) begin
            m_time = 0; m_winner = 0; m_cval = 0;
        end
        m_state = nst;
        m_ps = start_btn; m_pc = confirm_btn; m_pp = pause_btn;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("state", state, m_state);
        chk("countdown_val", countdown_val, m_cval);
        chk("race_time_cs", race_time_cs, m_time);
        chk("leader", leader, m_leader);
        chk("winner", winner, m_winner);
        chk("sec_pulse", sec_pulse, m_pulse);
    endtask

    task automatic press_start();
        start_btn = 1'b1; cycle(); start_btn = 1'b0; cycle();
    endtask

    task automatic start_race();
        int pulses;
        start_btn = 1'b1; cycle(); chk("to_setting", state, 1); start_btn = 1'b0;
        confirm_btn = 1'b1; cycle(); chk("to_countdown", state, 3);
        chk("cd_load", countdown_val, 3); confirm_btn = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 3000; i++) begin
            cycle();
            if (sec_pulse) pulses++;
            if (i == 999)  chk("cd_still_3", countdown_val, 3);
            if (i == 1000) chk("cd_2", countdown_val, 2);
            if (i == 2000) chk("cd_1", countdown_val, 1);
            if (i == 2999) chk("cd_not_yet_racing", state, 3);
        end
        chk("to_racing", state, 4);
        chk("race_start_time", race_time_cs, 0);
        chk("sec_pulse_count", pulses, 3);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_time", race_time_cs, 0);
        chk("rst_winner", winner, 0);
        chk("rst_cd", countdown_val, 0);
        rst = 1'b1;
        cycle();

        // Async reset in the middle of a race.
        start_race();
        repeat (35) cycle();
        #2 rst = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_time", race_time_cs, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle();

        // Race clock, pause hold, resume with prescaler phase kept.
        start_race();
        repeat (250) cycle();
        chk("time_250", race_time_cs, 25);
        pause_btn = 1'b1; cycle(); pause_btn = 1'b0;
        repeat (499) cycle();
        chk("paused_state", state, 5);
        chk("paused_time", race_time_cs, 25);
        pause_btn = 1'b1; cycle(); pause_btn = 1'b0;
        chk("resumed_state", state, 4);
        repeat (49) cycle();
        chk("resume_phase_time", race_time_cs, 30);

        // Leader tracking, then P1 finish.
        p1_flag = 2'd2; p2_flag = 2'd3;
        repeat (2) cycle();
        chk("leader_p2", leader, 2);
        p1_finish = 1'b1; cycle();
        chk("p1_fin_state", state, 6);
        chk("p1_fin_winner", winner, 1);
        chk("leader_fin_p1", leader, 1);
        p1_finish = 1'b0; p1_flag = 2'd1; p2_flag = 2'd1;
        repeat (2) cycle();
        chk("leader_tie", leader, 0);
        chk("finish_time_held", race_time_cs, 30);
        start_btn = 1'b1; cycle(); start_btn = 1'b0;
        chk("fin_to_idle", state, 0);
        chk("idle_winner", winner, 0);
        p1_flag = 2'd0; p2_flag = 2'd0;
        cycle();

        // Finish beats a simultaneous pause edge.
        start_race();
        repeat (100) cycle();
        p2_finish = 1'b1; pause_btn = 1'b1; cycle(); pause_btn = 1'b0;
        chk("fin_prio_state", state, 6);
        chk("fin_prio_winner", winner, 2);
        repeat (50) cycle();
        chk("fin_prio_time", race_time_cs, 10);
        p2_finish = 1'b0;
        press_start();

        // Both finish together.
        start_race();
        repeat (20) cycle();
        p1_finish = 1'b1; p2_finish = 1'b1; cycle();
        chk("tie_winner", winner, 3);
        p1_finish = 1'b0; p2_finish = 1'b0;
        press_start();

        // Finish already high in COUNTDOWN is taken on the first RACING cycle.
        p1_finish = 1'b1;
        start_race();
        cycle();
        chk("early_fin_state", state, 6);
        chk("early_fin_winner", winner, 1);
        p1_finish = 1'b0;
        press_start();

        // Saturation, then abort from PAUSE with a coincident pause edge.
        start_race();
        repeat (700) cycle();
        chk("saturated", race_time_cs, TMAX);
        pause_btn = 1'b1; cycle(); pause_btn = 1'b0;
        repeat (3) cycle();
        start_btn = 1'b1; pause_btn = 1'b1; cycle();
        chk("abort_state", state, 0);
        chk("abort_time", race_time_cs, 0);
        chk("abort_winner", winner, 0);
        chk("abort_leader", leader, 0);
        chk("abort_cd", countdown_val, 0);
        start_btn = 1'b0; pause_btn = 1'b0;
        cycle();

        // Randomized traffic; start is kept rare during COUNTDOWN so races complete.
        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(0, (m_state == 3) ? 7999 : 299) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 99) == 0)   confirm_btn = ~confirm_btn;
            if ($urandom_range(0, 149) == 0)  pause_btn = ~pause_btn;
            if ($urandom_range(0, 1499) == 0) p1_finish = ~p1_finish;
            if ($urandom_range(0, 1499) == 0) p2_finish = ~p2_finish;
            if ($urandom_range(0, 79) == 0)   p1_flag = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0)   p2_flag = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/race_flow_ctrl.md
Name: race_flow_ctrl

Overview:
Top-level game-flow state machine driving the 3-bit `state` bus into both PhysicsEngine instances (IDLE/SETTING/COUNTDOWN/RACING/PAUSE/FINISH encoding). It consumes each engine's `flag` and `finish` outputs and produces:
- the race clock,
- the 3-2-1 countdown value,
- the current leader,
- the latched winner.

Display and audio blocks read these outputs directly.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz; centisecond prescaler limit CS_LIMIT = CLK_FREQ/100 - 1.
- COUNTDOWN_SEC, 3, countdown length in seconds (1..7).
- TIME_MAX, 16'd59999, saturation value of the race clock in centiseconds.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start_btn  in  1  debounced level; rising edge = start / abort / return to idle.
- confirm_btn  in  1  debounced level; rising edge = leave SETTING.
- pause_btn  in  1  debounced level; rising edge = toggle pause.
- p1_flag  in  2  checkpoint index from player-1 engine.
- p2_flag  in  2  checkpoint index from player-2 engine.
- p1_finish  in  1  finish level from player-1 engine.
- p2_finish  in  1  finish level from player-2 engine.
- state  out  3  0=IDLE, 1=SETTING, 3=COUNTDOWN, 4=RACING, 5=PAUSE, 6=FINISH (2 and 7 never driven).
- countdown_val  out  3  seconds remaining; nonzero only in COUNTDOWN.
- race_time_cs  out  16  elapsed racing time in centiseconds.
- leader  out  2  0=tied, 1=P1 ahead, 2=P2 ahead.
- winner  out  2  0=none, 1=P1, 2=P2, 3=tie.
- sec_pulse  out  1  one-cycle pulse on each countdown second boundary (beeper).

Behaviour:
- Reset (rst=0, async): state=IDLE, countdown_val=0, race_time_cs=0, leader=0, winner=0, sec_pulse=0, prescaler=0, button edge registers=0.
- Edge detect: registered previous value per button; edge = btn & ~btn_q. State changes on the same clk edge at which the high level is first sampled (1-cycle latency). A held button never re-triggers.
- Prescaler: counts 0..CS_LIMIT only in COUNTDOWN and RACING. cs_tick=1 when it equals CS_LIMIT, then wraps to 0. It freezes in PAUSE (resumes from the held count) and clears in all other states.
- Second counter: 0..99 on cs_tick, used in COUNTDOWN only; cleared on COUNTDOWN entry.

Transitions:
- IDLE: start edge -> SETTING.
- SETTING: confirm edge -> COUNTDOWN; load countdown_val=COUNTDOWN_SEC; clear prescaler and second counter. start edge -> IDLE.
- COUNTDOWN: on each second boundary (cs_tick with sub-counter=99):
  - sec_pulse=1 for that cycle;
  - if countdown_val==1, then countdown_val<=0, race_time_cs<=0, winner<=0, and -> RACING;
  - else countdown_val decrements.
  - start edge -> IDLE (abort).
- RACING:
  - race_time_cs increments on cs_tick and saturates at TIME_MAX.
  - p1_finish|p2_finish -> FINISH with winner = {p2_finish, p1_finish} mapped as 01->1, 10->2, 11->3.
  - Otherwise, pause edge -> PAUSE.
  - Finish has priority over pause in the same cycle. A cs_tick coinciding with finish still increments the clock.
- PAUSE:
  - start edge -> IDLE (abort; has priority over pause).
  - Otherwise, pause edge -> RACING.
  - Clock and prescaler are held.
- FINISH: race_time_cs and winner are held. start edge -> IDLE.
- IDLE entry (from any state): race_time_cs=0, winner=0, countdown_val=0, prescaler cleared.
- leader: registered every cycle in RACING, PAUSE and FINISH, comparing {finish, flag} per player as unsigned 3-bit values (finish outranks flag=3). Greater value -> that player; equal -> 0. Forced to 0 in IDLE, SETTING and COUNTDOWN.
- Unreachable state codes (2, 7) recover to IDLE on the next clk.
- A finish level already high while in COUNTDOWN is ignored until RACING is entered; it is then taken on the first RACING cycle.

Test Plan:
- Reset and basic flow:
  - Setup: CLK_FREQ=1000 (CS_LIMIT=9).
  - Stimulus: assert rst=0 mid-RACING.
  - Required response: state=0 and race_time_cs=0 immediately without a clk edge.
  - Then: start edge -> state=1 next edge; confirm edge -> state=3, countdown_val=3.
- Countdown:
  - countdown_val reads 3,2,1, changing every 1000 cycles.
  - sec_pulse fires 3 times.
  - state=4 exactly 3000 cycles after COUNTDOWN entry, with race_time_cs=0.
- Race clock and pause:
  - 250 cycles of RACING -> race_time_cs=25.
  - Pause for 500 cycles -> still 25.
  - Resume for 55 cycles -> 30 (prescaler phase preserved).
- Finish priority:
  - p2_finish=1 and pause edge in the same cycle -> state=6, winner=2, race_time_cs frozen.
  - Separately, both finishes in the same cycle -> winner=3.
- Leader:
  - p1_flag=2, p2_flag=3 -> leader=2.
  - Then p1_finish=1 -> leader=1.
  - Equal flags, no finish -> leader=0.
- Saturation and abort:
  - Preload to TIME_MAX-1, run 20 cs ticks -> race_time_cs=59999.
  - start edge in PAUSE together with pause edge -> state=0, all outputs cleared.
